// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states and default datapath widths.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 64;
   localparam int ILEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD,
      ST_FLUSH
   } ifetch_state_t;

endpackage

// File: rtl/riscv_ifetch_watchdog.sv
// Watchdog that flags a fetch stuck waiting on memory for TIMEOUT_CYCLES cycles.
// Only present when IFETCH_TIMEOUT_EN is defined.
`ifdef IFETCH_TIMEOUT_EN
module riscv_ifetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic in_wait,
   output logic fetch_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] wait_cnt;

   // Leaving WAIT clears the count, so every fresh entry starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (!in_wait) begin
            wait_cnt <= '0;
         end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (in_wait && (wait_cnt == LIMIT - 1'b1)) begin
            fetch_err <= 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/riscv_ifetch_requester.sv
// Instruction fetch requester: launches one memory read at a time and holds the word until consumed.
// Optional watchdog output fetch_err is built when IFETCH_TIMEOUT_EN is defined.
module riscv_ifetch_requester
   import riscv_pkg::*;
#(
   parameter int XLEN           = XLEN_DEFAULT,
   parameter int ILEN           = ILEN_DEFAULT,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_req,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   input  logic            instr_ack,
   input  logic            mem_ready,
   input  logic [ILEN-1:0] mem_rdata,
   output logic            rden,
   output logic [XLEN-1:0] mem_addr,
   output logic [ILEN-1:0] instr,
   output logic            instr_valid,
`ifdef IFETCH_TIMEOUT_EN
   output logic            fetch_err,
`endif
   output logic            stall
);

   ifetch_state_t   state, state_next;
   logic            rden_next;
   logic [XLEN-1:0] addr_next;
   logic [ILEN-1:0] instr_next;
   logic            valid_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rden        <= 1'b0;
         mem_addr    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         rden        <= rden_next;
         mem_addr    <= addr_next;
         instr       <= instr_next;
         instr_valid <= valid_next;
      end
   end

   // rden only drops in WAIT on flush or data return; memory restarts its latency otherwise.
   always_comb begin
      state_next = state;
      rden_next  = rden;
      addr_next  = mem_addr;
      instr_next = instr;
      valid_next = instr_valid;
      if (flush) begin
         state_next = ST_FLUSH;
         rden_next  = 1'b0;
         valid_next = 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               rden_next = 1'b0;
               if (fetch_req) begin
                  addr_next  = pc;
                  rden_next  = 1'b1;
                  state_next = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_ready) begin
                  instr_next = mem_rdata;
                  valid_next = 1'b1;
                  rden_next  = 1'b0;
                  state_next = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (instr_ack) begin
                  valid_next = 1'b0;
                  if (fetch_req) begin
                     addr_next  = pc;
                     rden_next  = 1'b1;
                     state_next = ST_WAIT;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               rden_next  = 1'b0;
               state_next = ST_IDLE;
            end
            default: begin
               rden_next  = 1'b0;
               valid_next = 1'b0;
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign stall = fetch_req && (state != ST_HOLD);

`ifdef IFETCH_TIMEOUT_EN
   riscv_ifetch_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .in_wait   (state == ST_WAIT),
      .fetch_err (fetch_err)
   );
`else
   // The limit only matters when the watchdog is built; keep it referenced here.
   if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
   end
`endif

endmodule

// File: tb/tb_riscv_ifetch_requester.sv
// Self-checking bench for riscv_ifetch_requester: directed fetch scenarios plus random traffic
// against a transaction-level reference model and a fixed-latency memory model.
module tb_riscv_ifetch_requester;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            fetch_req = 1'b0;
   logic [XLEN-1:0] pc = '0;
   logic            flush = 1'b0;
   logic            instr_ack = 1'b0;
   logic            mem_ready = 1'b0;
   logic [ILEN-1:0] mem_rdata = '0;
   logic            rden;
   logic [XLEN-1:0] mem_addr;
   logic [ILEN-1:0] instr;
   logic            instr_valid;
   logic            stall;
`ifdef IFETCH_TIMEOUT_EN
   logic            fetch_err;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: what the fetch unit promises, in terms of outstanding/held fetches.
   logic            m_reading = 1'b0;
   logic            m_holding = 1'b0;
   logic            m_flushing = 1'b0;
   logic [XLEN-1:0] m_addr = '0;
   logic [ILEN-1:0] m_instr = '0;

   // Memory model: answers once rden has been seen high on 4 consecutive edges.
   int   mem_cnt = 0;
   logic mem_en = 1'b1;

   always #5 clk = ~clk;

   riscv_ifetch_requester #(
      .XLEN (XLEN),
      .ILEN (ILEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .pc          (pc),
      .flush       (flush),
      .instr_ack   (instr_ack),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .rden        (rden),
      .mem_addr    (mem_addr),
      .instr       (instr),
      .instr_valid (instr_valid),
`ifdef IFETCH_TIMEOUT_EN
      .fetch_err   (fetch_err),
`endif
      .stall       (stall)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs, check stall, advance the model, clock, check registered outputs.
   task automatic applyStimulus(input logic req, input logic [XLEN-1:0] p, input logic fl,
                                input logic ack, input logic rs, input logic stray,
                                input logic [ILEN-1:0] data);
      logic rden_seen;
      logic ready_now;
      ready_now = stray || (mem_en && (mem_cnt == 4));
      fetch_req = req;
      pc        = p;
      flush     = fl;
      instr_ack = ack;
      rst       = rs;
      mem_ready = ready_now;
      mem_rdata = data;
      #1;
      checkOutput("stall", stall, req && !m_holding);
      rden_seen = rden;
      if (rs) begin
         m_reading  = 1'b0;
         m_holding  = 1'b0;
         m_flushing = 1'b0;
         m_addr     = '0;
         m_instr    = '0;
      end else if (fl) begin
         m_reading  = 1'b0;
         m_holding  = 1'b0;
         m_flushing = 1'b1;
      end else if (m_flushing) begin
         m_flushing = 1'b0;
      end else if (m_reading) begin
         if (ready_now) begin
            m_instr   = data;
            m_holding = 1'b1;
            m_reading = 1'b0;
         end
      end else if (m_holding) begin
         if (ack) begin
            m_holding = 1'b0;
            if (req) begin
               m_reading = 1'b1;
               m_addr    = p;
            end
         end
      end else if (req) begin
         m_reading = 1'b1;
         m_addr    = p;
      end
      @(posedge clk);
      #1;
      if (ready_now || !rden_seen) mem_cnt = 0;
      else mem_cnt++;
      checkOutput("rden", rden, m_reading);
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("instr", instr, m_instr);
      checkOutput("instr_valid", instr_valid, m_holding);
   endtask

   // Keep requesting until a word arrives; returns the number of cycles taken from launch.
   task automatic fetchUntilValid(input logic [XLEN-1:0] p, input logic [ILEN-1:0] data, output int n);
      n = 0;
      while (!instr_valid && n < 20) begin
         applyStimulus(1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0, data);
         n++;
      end
   endtask

   initial begin
      int n;
      logic [ILEN-1:0] d;
      logic [ILEN-1:0] d_keep;
      logic [XLEN-1:0] rp;

      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      mem_cnt = 0;
      checkOutput("reset_rden", rden, 1'b0);
      checkOutput("reset_valid", instr_valid, 1'b0);
      checkOutput("reset_instr", instr, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

`ifdef IFETCH_TIMEOUT_EN
      checkOutput("wd_reset", fetch_err, 1'b0);
      mem_en = 1'b0;
      applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput("wd_before_limit", fetch_err, 1'b0);
      applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput("wd_at_limit", fetch_err, 1'b1);
      applyStimulus(1'b0, 64'h3000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput("wd_sticky_flush", fetch_err, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      checkOutput("wd_cleared_rst", fetch_err, 1'b0);
      mem_en  = 1'b1;
      mem_cnt = 0;
`endif

      // Single fetch from 0x1000.
      fetchUntilValid(64'h1000, 32'h00500093, n);
      checkOutput("single_latency", n, 6);
      checkOutput("single_instr", instr, 32'h00500093);

      // Back-to-back: ack in the first hold cycle relaunches directly.
      d = $urandom;
      applyStimulus(1'b1, 64'h1004, 1'b0, 1'b1, 1'b0, 1'b0, d);
      checkOutput("b2b_rden", rden, 1'b1);
      checkOutput("b2b_addr", mem_addr, 64'h1004);
      n = 1;
      while (!instr_valid && n < 20) begin
         applyStimulus(1'b1, 64'h1004, 1'b0, 1'b0, 1'b0, 1'b0, d);
         n++;
      end
      checkOutput("b2b_latency", n, 6);
      checkOutput("b2b_instr", instr, d);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

      // Flush in the third wait cycle, with a stale pulse during the flush cycle.
      applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 64'h3000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hdeadbeef);
      checkOutput("flush_stale_valid", instr_valid, 1'b0);
      d = $urandom;
      fetchUntilValid(64'h2000, d, n);
      checkOutput("after_flush_latency", n, 6);
      checkOutput("after_flush_instr", instr, d);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

      // Flush arriving together with the memory pulse.
      d_keep = d;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 64'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678);
      applyStimulus(1'b1, 64'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678);
      checkOutput("flush_ready_valid", instr_valid, 1'b0);
      checkOutput("flush_ready_instr", instr, d_keep);
      applyStimulus(1'b1, 64'h4000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput("flush_cycle_no_launch", rden, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Reset in the middle of a wait.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h5000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      checkOutput("rst_wait_rden", rden, 1'b0);
      checkOutput("rst_wait_addr", mem_addr, '0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hcafef00d);
      checkOutput("rst_wait_late_pulse", instr_valid, 1'b0);
      checkOutput("rst_wait_instr", instr, '0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rp = {$urandom, $urandom} & ~64'h3;
         applyStimulus($urandom_range(0, 9) < 7, rp, $urandom_range(0, 19) == 0,
                       1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
                       !m_reading && ($urandom_range(0, 9) == 0), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
